// File: rtl/regfile_alu_pkg.sv
// Shared definitions for the register-file/ALU unit: opcodes, flag bit
// positions and the sequencing FSM encoding.
package regfile_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_G = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU. Produces the truncated result, the C/V/Z/G
// flag candidates and whether the result should be written back.
module alu_core
    import regfile_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_r,
    output logic              o_c,
    output logic              o_v,
    output logic              o_z,
    output logic              o_g,
    output logic              o_we
);

    localparam int M = DATA_W - 1;

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic [DATA_W:0] w_inc;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_inc  = {1'b0, i_a} + {{DATA_W{1'b0}}, 1'b1};

    // Opcode decode; the extra top bit of the wide sums is carry/borrow.
    always_comb begin
        o_r  = '0;
        o_c  = 1'b0;
        o_v  = 1'b0;
        o_g  = 1'b0;
        o_we = 1'b1;
        o_z  = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_r = w_sum[DATA_W-1:0];
                o_c = w_sum[DATA_W];
                o_v = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
            end
            OP_SUB, OP_CMP: begin
                o_r = w_diff[DATA_W-1:0];
                o_c = w_diff[DATA_W];
                o_v = (i_a[M] != i_b[M]) && (w_diff[M] != i_a[M]);
                if (i_op == OP_CMP) begin
                    o_g  = (i_a > i_b);
                    o_we = 1'b0;
                end
            end
            OP_INC: begin
                o_r = w_inc[DATA_W-1:0];
                o_c = w_inc[DATA_W];
                // B=1 has a clear msb, so overflow is a 0->1 msb flip
                o_v = (i_a[M] == 1'b0) && (w_inc[M] != i_a[M]);
            end
            OP_AND: o_r = i_a & i_b;
            OP_OR:  o_r = i_a | i_b;
            OP_XOR: o_r = i_a ^ i_b;
            OP_SHL: begin
                o_r = {i_a[DATA_W-2:0], 1'b0};
                o_c = i_a[M];
            end
            default: o_r = '0;
        endcase
        o_z = (o_r == '0);
    end

endmodule

// File: rtl/regfile_alu_unit.sv
// Register file with host port and a three-state ALU sequencer.
// state   | meaning
// IDLE    | ready; accept op, latch opcode/dst and operands
// EXEC    | compute result and flag candidates
// WB      | write back (not CMP), pulse res_valid, update flags
module regfile_alu_unit
    import regfile_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic              mem_re,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rvalid,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_sel,
    input  logic [ADDR_W-1:0] op_src_a,
    input  logic [ADDR_W-1:0] op_src_b,
    input  logic [ADDR_W-1:0] op_dst,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [3:0]        flags
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;

    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res;
    logic              r_c, r_v, r_z, r_g, r_we;

    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_mem_rvalid;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic [3:0]        r_flags;

    logic [DATA_W-1:0] w_r;
    logic              w_c, w_v, w_z, w_g, w_we;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_r  (w_r),
        .o_c  (w_c),
        .o_v  (w_v),
        .o_z  (w_z),
        .o_g  (w_g),
        .o_we (w_we)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state, accept and ready decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        op_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_WB;
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture at accept; ALU outputs registered in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op  <= '0;
            r_dst <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
            r_z   <= 1'b0;
            r_g   <= 1'b0;
            r_we  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op_sel;
                r_dst <= op_dst;
                r_a   <= r_regs[op_src_a];
                r_b   <= r_regs[op_src_b];
            end
            if (r_state == ST_EXEC) begin
                r_res <= w_r;
                r_c   <= w_c;
                r_v   <= w_v;
                r_z   <= w_z;
                r_g   <= w_g;
                r_we  <= w_we;
            end
        end
    end

    // Storage; the ALU writeback is last so it overrides a colliding host write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            if (mem_we) r_regs[mem_addr] <= mem_wdata;
            if ((r_state == ST_WB) && r_we) r_regs[r_dst] <= r_res;
        end
    end

    // Host read port, one-cycle latency, returns pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_rdata  <= '0;
            r_mem_rvalid <= 1'b0;
        end else begin
            r_mem_rvalid <= mem_re;
            if (mem_re) r_mem_rdata <= r_regs[mem_addr];
        end
    end

    // Result/flag publish at writeback; G only moves on CMP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_flags     <= '0;
        end else begin
            r_res_valid <= (r_state == ST_WB);
            if (r_state == ST_WB) begin
                r_res_data      <= r_res;
                r_flags[FLAG_C] <= r_c;
                r_flags[FLAG_V] <= r_v;
                r_flags[FLAG_Z] <= r_z;
                if (r_op == OP_CMP) r_flags[FLAG_G] <= r_g;
            end
        end
    end

    assign mem_rdata  = r_mem_rdata;
    assign mem_rvalid = r_mem_rvalid;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign flags      = r_flags;

endmodule

// File: tb/tb_regfile_alu_unit.sv
// Scoreboard bench for regfile_alu_unit with a behavioural reference model.
module tb_regfile_alu_unit;
    import regfile_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_we, mem_re;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_rvalid;
    logic       op_valid, op_ready;
    logic [2:0] op_sel;
    logic [4:0] op_src_a, op_src_b, op_dst;
    logic       res_valid;
    logic [7:0] res_data;
    logic [3:0] flags;

    always #5 clk = ~clk;

    regfile_alu_unit #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .op_valid(op_valid), .op_ready(op_ready), .op_sel(op_sel),
        .op_src_a(op_src_a), .op_src_b(op_src_b), .op_dst(op_dst),
        .res_valid(res_valid), .res_data(res_data), .flags(flags)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] flg;
    } res_t;

    res_t       res_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] model[32];
    logic [3:0] mflags;
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference from the opcode definitions, on plain integers.
    task automatic ref_op(input int sel, input int a, input int b,
                          output int r, output logic [3:0] f, output bit wb);
        int s, bb;
        bit c, v;
        wb = 1'b1; c = 1'b0; v = 1'b0; f = mflags; r = 0; bb = b;
        case (sel)
            0, 3: begin
                if (sel == 3) bb = 1;
                s = a + bb;
                r = s % 256;
                c = (s > 255);
                v = ((a / 128) == (bb / 128)) && ((r / 128) != (a / 128));
            end
            1, 2: begin
                r = (a - b + 256) % 256;
                c = (a < b);
                v = ((a / 128) != (b / 128)) && ((r / 128) != (a / 128));
                if (sel == 2) begin
                    wb   = 1'b0;
                    f[3] = (a > b);
                end
            end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: begin
                r = (a * 2) % 256;
                c = (a >= 128);
            end
        endcase
        f[0] = c;
        f[1] = v;
        f[2] = (r == 0);
    endtask

    task automatic host_rw(input bit we, input bit re, input logic [4:0] addr, input logic [7:0] data);
        mem_we = we; mem_re = re; mem_addr = addr; mem_wdata = data;
        if (re) rd_q.push_back(model[addr]);
        tick();
        if (we) model[addr] = data;
        mem_we = 1'b0; mem_re = 1'b0;
        if (re) check("rd_latency", 32'(mem_rvalid), 32'd1);
    endtask

    task automatic do_op(input logic [2:0] sel, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [4:0] dst, input bit hz_en, input logic [7:0] hz_data,
                         input bit col_en, input logic [4:0] col_addr, input logic [7:0] col_data);
        int r;
        logic [3:0] f;
        bit wb;
        res_t e;
        check("ready_idle", 32'(op_ready), 32'd1);
        ref_op(int'(sel), int'(model[sa]), int'(model[sb]), r, f, wb);
        e.data = 8'(r); e.flg = f;
        res_q.push_back(e);
        mflags = f;
        op_valid = 1'b1; op_sel = sel; op_src_a = sa; op_src_b = sb; op_dst = dst;
        tick();
        check("ready_exec", 32'(op_ready), 32'd0);
        check("lat_exec", 32'(res_valid), 32'd0);
        // an offer while busy must be ignored
        op_sel = 3'($urandom_range(0, 7)); op_dst = 5'($urandom_range(0, 31));
        if (hz_en) begin
            mem_we = 1'b1; mem_addr = sa; mem_wdata = hz_data;
        end
        tick();
        if (hz_en) model[sa] = hz_data;
        op_valid = 1'b0; mem_we = 1'b0;
        check("ready_wb", 32'(op_ready), 32'd0);
        check("lat_wb", 32'(res_valid), 32'd0);
        if (col_en) begin
            mem_we = 1'b1; mem_addr = col_addr; mem_wdata = col_data;
        end
        tick();
        mem_we = 1'b0;
        if (col_en && !(wb && col_addr == dst)) model[col_addr] = col_data;
        if (wb) model[dst] = 8'(r);
        check("lat_result", 32'(res_valid), 32'd1);
        check("ready_back", 32'(op_ready), 32'd1);
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (res_valid) begin
            if (res_q.size() == 0) begin
                total++; bad++;
                $display("FAIL res_unexpected: got data 0x%0h with no op pending", res_data);
            end else begin
                res_t e;
                e = res_q.pop_front();
                check("res_data", 32'(res_data), 32'(e.data));
                check("res_flags", 32'(flags), 32'(e.flg));
            end
        end
        if (mem_rvalid) begin
            if (rd_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got rdata 0x%0h with no read pending", mem_rdata);
            end else begin
                logic [7:0] d;
                d = rd_q.pop_front();
                check("rd_data", 32'(mem_rdata), 32'(d));
            end
        end
    end

    initial begin
        rst = 1'b1; mem_we = 0; mem_re = 0; mem_addr = 0; mem_wdata = 0;
        op_valid = 0; op_sel = 0; op_src_a = 0; op_src_b = 0; op_dst = 0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        mflags = 4'h0;
        tick(); tick();
        rst = 1'b0;
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_rvalid", 32'(mem_rvalid), 32'd0);
        check("rst_ready", 32'(op_ready), 32'd1);

        // reset while an ADD is in EXEC
        host_rw(1, 0, 5'd10, 8'h05);
        host_rw(1, 0, 5'd11, 8'h06);
        op_valid = 1; op_sel = OP_ADD; op_src_a = 10; op_src_b = 11; op_dst = 12;
        tick();
        op_valid = 0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        mflags = 4'h0;
        check("midrst_ready", 32'(op_ready), 32'd1);
        check("midrst_flags", 32'(flags), 32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("midrst_res_valid2", 32'(res_valid), 32'd0);
        check("midrst_res_data", 32'(res_data), 32'd0);
        host_rw(0, 1, 5'd12, 8'h00);
        host_rw(0, 1, 5'd10, 8'h00);

        // host write/read and same-cycle read+write
        host_rw(1, 0, 5'd3, 8'h5A);
        host_rw(0, 1, 5'd3, 8'h00);
        host_rw(1, 1, 5'd3, 8'h11);
        host_rw(0, 1, 5'd3, 8'h00);

        // ADD signed overflow
        host_rw(1, 0, 5'd0, 8'h7F);
        host_rw(1, 0, 5'd1, 8'h01);
        do_op(OP_ADD, 0, 1, 2, 0, 0, 0, 0, 0);
        check("add_flags", 32'(flags), 32'h2);
        host_rw(0, 1, 5'd2, 8'h00);

        // INC wrap, then a back-to-back op
        host_rw(1, 0, 5'd0, 8'hFF);
        do_op(OP_INC, 0, 0, 0, 0, 0, 0, 0, 0);
        check("inc_flags", 32'(flags), 32'h5);
        do_op(OP_OR, 1, 2, 9, 0, 0, 0, 0, 0);
        host_rw(0, 1, 5'd0, 8'h00);

        // CMP both ways, then AND leaves G clear
        host_rw(1, 0, 5'd4, 8'h09);
        host_rw(1, 0, 5'd5, 8'h03);
        host_rw(1, 0, 5'd6, 8'h77);
        do_op(OP_CMP, 4, 5, 6, 0, 0, 0, 0, 0);
        check("cmp_gt_flags", 32'(flags), 32'h8);
        do_op(OP_CMP, 5, 4, 6, 0, 0, 0, 0, 0);
        check("cmp_lt_flags", 32'(flags), 32'h1);
        do_op(OP_AND, 4, 5, 13, 0, 0, 0, 0, 0);
        check("and_flags", 32'(flags), 32'h0);
        host_rw(0, 1, 5'd6, 8'h00);

        // WB-cycle host writes: same address loses, other address lands
        host_rw(1, 0, 5'd14, 8'h20);
        host_rw(1, 0, 5'd15, 8'h05);
        do_op(OP_SUB, 14, 15, 7, 0, 0, 1, 5'd7, 8'hAA);
        do_op(OP_SUB, 14, 15, 7, 0, 0, 1, 5'd8, 8'hBB);
        host_rw(0, 1, 5'd7, 8'h00);
        host_rw(0, 1, 5'd8, 8'h00);

        // in-flight operand hazard with dst==src
        do_op(OP_SHL, 14, 14, 14, 1, 8'hC3, 0, 0, 0);
        host_rw(0, 1, 5'd14, 8'h00);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            logic [4:0] d;
            if ($urandom_range(0, 1) == 1)
                host_rw(1, 0, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            d = 5'($urandom_range(0, 31));
            do_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), d,
                  $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) == 0,
                  ($urandom_range(0, 1) == 1) ? d : 5'($urandom_range(0, 31)),
                  8'($urandom_range(0, 255)));
        end
        for (int a = 0; a < 32; a++) host_rw(0, 1, 5'(a), 8'h00);

        tick(); tick(); tick();
        check("res_q_drained", 32'(res_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
